// File: rtl/tx_arbiter.sv
// Output-port scheduler: round-robin grant among input receivers, then streams
// the granted buffer out one flit at a time over a 2-phase toggle req/ack link.

module tx_arbiter_elig #(
  parameter int CHANNEL_BITS = 3,
  parameter int CHANNEL_ID   = 0
) (
  input  logic                    req,
  input  logic [CHANNEL_BITS-1:0] chnl,
  output logic                    elig
);
  assign elig = req && (chnl == CHANNEL_BITS'(CHANNEL_ID));
endmodule

module tx_arbiter #(
  parameter int ID           = 0,
  parameter     MOD_NAME     = "TX",
  parameter int N_IN         = 4,
  parameter int SIZE         = 8,
  parameter int CHANNEL_BITS = 3,
  parameter int BUFF_BITS    = 3,
  parameter int CHANNEL_ID   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_IN-1:0]              in_req,
  input  logic [N_IN*CHANNEL_BITS-1:0] in_chnl,
  output logic [N_IN-1:0]              in_gnt,
  output logic [BUFF_BITS-1:0]         buf_addr,
  input  logic [N_IN*SIZE-1:0]         buf_data,
  output logic                         ch_req,
  output logic [SIZE-1:0]              ch_flit,
  input  logic                         ch_ack
);
  localparam int PW = $clog2(N_IN);
  localparam logic [BUFF_BITS-1:0] LAST_ADDR = BUFF_BITS'((2**BUFF_BITS) - 1);
  localparam logic [PW-1:0]        LAST_IN   = PW'(N_IN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, RELEASE} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr, sel, winner;
  logic            ack_old;
  logic            ack_evt;
  logic [N_IN-1:0] elig;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    tx_arbiter_elig #(.CHANNEL_BITS(CHANNEL_BITS), .CHANNEL_ID(CHANNEL_ID)) u_elig (
      .req  (in_req[i]),
      .chnl (in_chnl[i*CHANNEL_BITS +: CHANNEL_BITS]),
      .elig (elig[i])
    );
  end

  assign ack_evt = ch_ack ^ ack_old;

  // First eligible index scanning cyclically from rr_ptr.
  always_comb begin
    logic         found;
    logic [PW:0]  sum;
    logic [PW-1:0] idx;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N_IN; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_IN)) sum = sum - (PW+1)'(N_IN);
      idx = sum[PW-1:0];
      if (!found && elig[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      sel      <= '0;
      ack_old  <= 1'b0;
      in_gnt   <= '0;
      buf_addr <= '0;
      ch_req   <= 1'b0;
      ch_flit  <= '0;
    end else begin
      ack_old <= ch_ack;
      case (state)
        IDLE: if (|elig) begin
          sel            <= winner;
          in_gnt         <= '0;
          in_gnt[winner] <= 1'b1;
          buf_addr       <= '0;
          state          <= LOAD;
        end
        LOAD: begin
          ch_flit <= buf_data[sel*SIZE +: SIZE];
          ch_req  <= ~ch_req;
          state   <= WAIT_ACK;
        end
        // Acks seen outside this state are dropped, since ack_old tracks every cycle.
        WAIT_ACK: if (ack_evt) begin
          if (buf_addr != LAST_ADDR) begin
            buf_addr <= buf_addr + 1'b1;
            state    <= LOAD;
          end else begin
            in_gnt   <= '0;
            rr_ptr   <= (sel == LAST_IN) ? '0 : sel + 1'b1;
            buf_addr <= '0;
            state    <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
